// File: rtl/register_file_mp.sv
// Multi-port register file. The top index aliases the PC. Includes same-cycle write bypass and a busy scoreboard.
// Optional macro RF_ZERO_REG_EN makes register 0 a hardwired zero.
module register_file_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 16,
  parameter int NUM_RD    = 3,
  parameter int PC_OFFSET = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [DATA_W-1:0]        pc_in,
  output logic                     pc_wr_en,
  output logic [DATA_W-1:0]        pc_wr_data,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     wr_conflict
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PC_IDX = NUM_REGS - 1;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Tables span the full address space so out-of-range indices read as 0 and are never written.
  logic [DATA_W-1:0]        storage_r [DEPTH];
  logic [DATA_W-1:0]        rv_s      [DEPTH];
  logic [DEPTH-1:0]         busy_r, busy_nxt_s, rb_s;
  logic [DEPTH-1:0]         wr0_hit_s, wr1_hit_s, rsv_hit_s;
  logic                     conflict_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_r, rd_data_nxt_s;
  logic [NUM_RD-1:0]        rd_busy_r, rd_busy_nxt_s;
  logic                     pc_wr_en_r, wr_conflict_r;
  logic [DATA_W-1:0]        pc_wr_data_r;

  // Decode the write ports and the reservation into per-index hit vectors.
  always_comb begin
    wr0_hit_s = {DEPTH{1'b0}};
    wr1_hit_s = {DEPTH{1'b0}};
    rsv_hit_s = {DEPTH{1'b0}};
    for (int r = 0; r < DEPTH; r++) begin
      if ((r < NUM_REGS) && !(ZERO_REG && (r == 0))) begin
        wr0_hit_s[r] = we0 && (wa0 == ADDR_W'(r));
        wr1_hit_s[r] = we1 && (wa1 == ADDR_W'(r));
        rsv_hit_s[r] = rsv_en && (rsv_addr == ADDR_W'(r)) && (r != PC_IDX);
      end else begin
        wr0_hit_s[r] = 1'b0;
        wr1_hit_s[r] = 1'b0;
        rsv_hit_s[r] = 1'b0;
      end
    end
    conflict_s = |(wr0_hit_s & wr1_hit_s);
  end

  // Value and busy flag a reader of each index sees this cycle, bypass included.
  always_comb begin
    rb_s = {DEPTH{1'b0}};
    for (int r = 0; r < DEPTH; r++) begin
      rv_s[r] = {DATA_W{1'b0}};
      if (r == PC_IDX) begin
        rv_s[r] = pc_in + DATA_W'(PC_OFFSET);
        rb_s[r] = 1'b0;
      end else if (wr0_hit_s[r]) begin
        rv_s[r] = wd0;
        rb_s[r] = rsv_hit_s[r];
      end else if (wr1_hit_s[r]) begin
        rv_s[r] = wd1;
        rb_s[r] = rsv_hit_s[r];
      end else if ((r < NUM_REGS) && !(ZERO_REG && (r == 0))) begin
        rv_s[r] = storage_r[r];
        rb_s[r] = busy_r[r];
      end else begin
        rv_s[r] = {DATA_W{1'b0}};
        rb_s[r] = 1'b0;
      end
    end
  end

  // Scoreboard next state: a new reservation beats a completing write.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < DEPTH; r++) begin
      if (rsv_hit_s[r]) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr0_hit_s[r] || wr1_hit_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Read port muxing; disabled ports hold their last value.
  always_comb begin
    rd_data_nxt_s = rd_data_r;
    rd_busy_nxt_s = rd_busy_r;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_en[k]) begin
        rd_data_nxt_s[k*DATA_W +: DATA_W] = rv_s[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy_nxt_s[k]                  = rb_s[rd_addr[k*ADDR_W +: ADDR_W]];
      end else begin
        rd_data_nxt_s[k*DATA_W +: DATA_W] = rd_data_r[k*DATA_W +: DATA_W];
        rd_busy_nxt_s[k]                  = rd_busy_r[k];
      end
    end
  end

  // Storage array update; port 0 wins on a shared address and the PC index is never stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) storage_r[r] <= {DATA_W{1'b0}};
    end else begin
      for (int r = 0; r < PC_IDX; r++) begin
        if (wr0_hit_s[r])      storage_r[r] <= wd0;
        else if (wr1_hit_s[r]) storage_r[r] <= wd1;
      end
    end
  end

  // Registered outputs: read ports, scoreboard, PC request and sticky conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r     <= {(NUM_RD*DATA_W){1'b0}};
      rd_busy_r     <= {NUM_RD{1'b0}};
      busy_r        <= {DEPTH{1'b0}};
      pc_wr_en_r    <= 1'b0;
      pc_wr_data_r  <= {DATA_W{1'b0}};
      wr_conflict_r <= 1'b0;
    end else begin
      rd_data_r     <= rd_data_nxt_s;
      rd_busy_r     <= rd_busy_nxt_s;
      busy_r        <= busy_nxt_s;
      pc_wr_en_r    <= wr0_hit_s[PC_IDX] || wr1_hit_s[PC_IDX];
      if (wr0_hit_s[PC_IDX])      pc_wr_data_r <= wd0;
      else if (wr1_hit_s[PC_IDX]) pc_wr_data_r <= wd1;
      if (conflict_s) wr_conflict_r <= 1'b1;
    end
  end

  assign rd_data     = rd_data_r;
  assign rd_busy     = rd_busy_r;
  assign busy_vec    = busy_r[NUM_REGS-1:0];
  assign pc_wr_en    = pc_wr_en_r;
  assign pc_wr_data  = pc_wr_data_r;
  assign wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed vector table, mid-stream reset sequence, then random traffic
// checked against an array-based reference model.
module tb_register_file_mp;
  localparam int DW = 32, AW = 4, NR = 16, NRD = 3, PCO = 8;
`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0, rst;
  logic [NRD-1:0] rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic we0, we1, rsv_en, pc_wr_en, wr_conflict;
  logic [AW-1:0] wa0, wa1, rsv_addr;
  logic [DW-1:0] wd0, wd1, pc_in, pc_wr_data;
  logic [NR-1:0] busy_vec;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NRD), .PC_OFFSET(PCO)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pc_in(pc_in), .pc_wr_en(pc_wr_en),
    .pc_wr_data(pc_wr_data), .busy_vec(busy_vec), .wr_conflict(wr_conflict));

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_en = '0; rd_addr = '0; we0 = 1'b0; wa0 = '0; wd0 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0;
    rsv_en = 1'b0; rsv_addr = '0; pc_in = '0;
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_reg [NR];
  logic [NR-1:0] m_busy;
  logic [DW-1:0] e_d [NRD];
  logic [NRD-1:0] e_b;
  logic e_pcen, e_conf;
  logic [DW-1:0] e_pcd;

  function automatic bit zr(input int a);
    return ZR && (a == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    for (int k = 0; k < NRD; k++) e_d[k] = '0;
    m_busy = '0; e_b = '0; e_pcen = 1'b0; e_pcd = '0; e_conf = 1'b0;
  endtask

  task automatic model_step();
    int a;
    for (int k = 0; k < NRD; k++) begin
      if (rd_en[k]) begin
        a = int'(rd_addr[k*AW +: AW]);
        if (a == NR - 1) begin
          e_d[k] = pc_in + PCO; e_b[k] = 1'b0;
        end else if (zr(a)) begin
          e_d[k] = '0; e_b[k] = 1'b0;
        end else if (we0 && int'(wa0) == a) begin
          e_d[k] = wd0; e_b[k] = rsv_en && int'(rsv_addr) == a;
        end else if (we1 && int'(wa1) == a) begin
          e_d[k] = wd1; e_b[k] = rsv_en && int'(rsv_addr) == a;
        end else begin
          e_d[k] = m_reg[a]; e_b[k] = m_busy[a];
        end
      end
    end
    e_pcen = 1'b0;
    if (we0 && int'(wa0) == NR - 1) begin e_pcen = 1'b1; e_pcd = wd0; end
    else if (we1 && int'(wa1) == NR - 1) begin e_pcen = 1'b1; e_pcd = wd1; end
    if (we0 && we1 && wa0 == wa1 && !zr(int'(wa0))) e_conf = 1'b1;
    // port 1 first so that port 0 overwrites it on a shared address
    if (we1 && int'(wa1) < NR - 1 && !zr(int'(wa1))) begin m_reg[wa1] = wd1; m_busy[wa1] = 1'b0; end
    if (we0 && int'(wa0) < NR - 1 && !zr(int'(wa0))) begin m_reg[wa0] = wd0; m_busy[wa0] = 1'b0; end
    if (rsv_en && int'(rsv_addr) < NR - 1 && !zr(int'(rsv_addr))) m_busy[rsv_addr] = 1'b1;
  endtask

  task automatic check_model(input int cyc);
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rand%0d rd_data[%0d]", cyc, k), rd_data[k*DW +: DW], e_d[k]);
      chk($sformatf("rand%0d rd_busy[%0d]", cyc, k), rd_busy[k], e_b[k]);
    end
    chk($sformatf("rand%0d busy_vec", cyc), busy_vec, m_busy);
    chk($sformatf("rand%0d pc_wr_en", cyc), pc_wr_en, e_pcen);
    if (e_pcen) chk($sformatf("rand%0d pc_wr_data", cyc), pc_wr_data, e_pcd);
    chk($sformatf("rand%0d wr_conflict", cyc), wr_conflict, e_conf);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic rs; logic [AW-1:0] ra; logic re; logic [AW-1:0] rda; logic [DW-1:0] pc;
    logic [DW-1:0] ed; logic eb; logic epcen; logic [DW-1:0] epcd; logic econf; logic [NR-1:0] ebv;
  } vec_t;

  function automatic vec_t mk(input logic w0, input int a0, input logic [DW-1:0] d0,
                              input logic w1, input int a1, input logic [DW-1:0] d1,
                              input logic rs, input int ra, input logic re, input int rda,
                              input logic [DW-1:0] pc, input logic [DW-1:0] ed, input logic eb,
                              input logic epcen, input logic [DW-1:0] epcd, input logic econf,
                              input logic [NR-1:0] ebv);
    vec_t v;
    v.w0 = w0; v.a0 = AW'(a0); v.d0 = d0; v.w1 = w1; v.a1 = AW'(a1); v.d1 = d1;
    v.rs = rs; v.ra = AW'(ra); v.re = re; v.rda = AW'(rda); v.pc = pc;
    v.ed = ed; v.eb = eb; v.epcen = epcen; v.epcd = epcd; v.econf = econf; v.ebv = ebv;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    //            w0 a0 d0            w1 a1 d1     rs ra re rda pc             ed            eb pcen pcd     conf busy_vec
    tbl[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0,      0, 0, 1, 3,  0,             32'hDEADBEEF, 0, 0, 0,       0, 16'h0000);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 1, 3,  0,             32'hDEADBEEF, 0, 0, 0,       0, 16'h0000);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 1, 15, 32'h100,       32'h108,      0, 0, 0,       0, 16'h0000);
    tbl[3]  = mk(0, 0, 0,            1, 15, 32'h200, 0, 0, 1, 14, 32'h100,     32'h0,        0, 1, 32'h200, 0, 16'h0000);
    tbl[4]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 1, 14, 32'h100,       32'h0,        0, 0, 0,       0, 16'h0000);
    tbl[5]  = mk(1, 5, 32'h11,       1, 5, 32'h22, 0, 0, 1, 5,  0,             32'h11,       0, 0, 0,       1, 16'h0000);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 1, 5,  0,             32'h11,       0, 0, 0,       1, 16'h0000);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,      1, 7, 1, 7,  0,             32'h0,        0, 0, 0,       1, 16'h0080);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 1, 7,  0,             32'h0,        1, 0, 0,       1, 16'h0080);
    tbl[9]  = mk(1, 7, 32'h5,        0, 0, 0,      0, 0, 1, 7,  0,             32'h5,        0, 0, 0,       1, 16'h0000);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,      1, 7, 1, 7,  0,             32'h5,        0, 0, 0,       1, 16'h0080);
    tbl[11] = mk(0, 0, 0,            1, 7, 32'h9,  1, 7, 1, 7,  0,             32'h9,        1, 0, 0,       1, 16'h0080);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,      0, 0, 1, 7,  0,             32'h9,        1, 0, 0,       1, 16'h0080);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,      0, 0, 1, 15, 32'hFFFFFFFC,  32'h4,        0, 0, 0,       1, 16'h0080);
    tbl[14] = mk(0, 0, 0,            0, 0, 0,      0, 0, 0, 3,  0,             32'h4,        0, 0, 0,       1, 16'h0080);

    clear_inputs();
    rst = 1'b0;
    #12;
    chk("reset rd_data", rd_data, '0);
    chk("reset rd_busy", rd_busy, '0);
    chk("reset busy_vec", busy_vec, '0);
    chk("reset pc_wr_en", pc_wr_en, 1'b0);
    chk("reset pc_wr_data", pc_wr_data, '0);
    chk("reset wr_conflict", wr_conflict, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // every storage register reads zero after reset, rotating over the read ports
    for (int a = 0; a < NR - 1; a++) begin
      rd_en = NRD'(1 << (a % NRD));
      rd_addr = {NRD{AW'(a)}};
      tick();
      chk($sformatf("post-reset r%0d", a), rd_data[(a % NRD)*DW +: DW], '0);
    end

    for (int i = 0; i < 15; i++) begin
      clear_inputs();
      we0 = tbl[i].w0; wa0 = tbl[i].a0; wd0 = tbl[i].d0;
      we1 = tbl[i].w1; wa1 = tbl[i].a1; wd1 = tbl[i].d1;
      rsv_en = tbl[i].rs; rsv_addr = tbl[i].ra; pc_in = tbl[i].pc;
      rd_en = {2'b00, tbl[i].re}; rd_addr = {8'h00, tbl[i].rda};
      tick();
      chk($sformatf("vec%0d rd_data0", i), rd_data[DW-1:0], tbl[i].ed);
      chk($sformatf("vec%0d rd_busy0", i), rd_busy[0], tbl[i].eb);
      chk($sformatf("vec%0d pc_wr_en", i), pc_wr_en, tbl[i].epcen);
      if (tbl[i].epcen) chk($sformatf("vec%0d pc_wr_data", i), pc_wr_data, tbl[i].epcd);
      chk($sformatf("vec%0d wr_conflict", i), wr_conflict, tbl[i].econf);
      chk($sformatf("vec%0d busy_vec", i), busy_vec, tbl[i].ebv);
    end

    // mid-stream reset with a pending PC request and outstanding reservations
    clear_inputs();
    we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h1234; rsv_en = 1'b1; rsv_addr = 4'd2;
    rd_en = 3'b111; rd_addr = {4'd7, 4'd3, 4'd15}; pc_in = 32'h40;
    tick();
    chk("pre-abort pc_wr_en", pc_wr_en, 1'b1);
    chk("pre-abort busy_vec", busy_vec, 16'h0084);
    clear_inputs();
    #2 rst = 1'b0;
    #1;
    chk("abort rd_data", rd_data, '0);
    chk("abort rd_busy", rd_busy, '0);
    chk("abort busy_vec", busy_vec, '0);
    chk("abort pc_wr_en", pc_wr_en, 1'b0);
    chk("abort pc_wr_data", pc_wr_data, '0);
    chk("abort wr_conflict", wr_conflict, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

`ifdef RF_ZERO_REG_EN
    we0 = 1'b1; wa0 = 4'd0; wd0 = 32'hFF; rsv_en = 1'b1; rsv_addr = 4'd0;
    tick();
    clear_inputs();
    rd_en = 3'b001;
    tick();
    chk("zero-reg read", rd_data[DW-1:0], '0);
    chk("zero-reg busy", busy_vec[0], 1'b0);
    for (int k = 0; k < NRD; k++) e_d[k] = rd_data[k*DW +: DW] === '0 ? '0 : 32'hBAD0BAD0;
`endif

    // random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, NR - 1)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, NR - 1)); wd1 = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = AW'($urandom_range(0, NR - 1));
      rd_en = NRD'($urandom_range(0, 7)); rd_addr = NRD*AW'($urandom); pc_in = $urandom;
      model_step();
      tick();
      check_model(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
